// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline compositor: layer mode encodings and the
// default chroma-key colour.
package pipeline_pkg;

  typedef enum logic [1:0] {
    MODE_NONE    = 2'd0,
    MODE_CHROMA  = 2'd1,
    MODE_OVERLAY = 2'd2,
    MODE_BLEND   = 2'd3
  } layer_mode_t;

  localparam int          MODE_WIDTH        = 2;
  localparam logic [15:0] DEFAULT_KEY_COLOR = 16'h258C;

endpackage

// File: rtl/pipeline_compositor_if.sv
// Video stream bundle for the compositor: pixel position, background and
// foreground inputs, layer control, and the composited output stream.
interface pipeline_compositor_if #(
  parameter int PIXEL_SIZE = 16,
  parameter int PRECISION  = 11,
  parameter int NUM_LAYERS = 2
);

  logic [PRECISION-1:0]             pixel_x;
  logic [PRECISION-1:0]             pixel_y;
  logic [PIXEL_SIZE-1:0]            bg_pixel_in;
  logic                             output_enable;
  logic [NUM_LAYERS*PIXEL_SIZE-1:0] fg_pixel_in;
  logic [NUM_LAYERS-1:0]            fg_pixel_skip;
  logic [2*NUM_LAYERS-1:0]          ctrl_layer_mode;

  logic [PIXEL_SIZE-1:0]            pixel_out;
  logic [PRECISION-1:0]             pixel_x_out;
  logic [PRECISION-1:0]             pixel_y_out;
  logic                             pixel_valid_out;
  logic                             frame_start_out;

  modport master (
    output pixel_x, pixel_y, bg_pixel_in, output_enable,
           fg_pixel_in, fg_pixel_skip, ctrl_layer_mode,
    input  pixel_out, pixel_x_out, pixel_y_out, pixel_valid_out, frame_start_out
  );

  modport slave (
    input  pixel_x, pixel_y, bg_pixel_in, output_enable,
           fg_pixel_in, fg_pixel_skip, ctrl_layer_mode,
    output pixel_out, pixel_x_out, pixel_y_out, pixel_valid_out, frame_start_out
  );

endinterface

// File: rtl/pipeline_layer_mix.sv
// Combinational mixer for one foreground layer over the running composite.
// 50% blend exists only when PIPELINE_COMPOSITOR_BLEND_EN is defined.
module pipeline_layer_mix
  import pipeline_pkg::*;
#(
  parameter int                    PIXEL_SIZE = 16,
  parameter int                    RED_SIZE   = 5,
  parameter int                    GREEN_SIZE = 6,
  parameter logic [PIXEL_SIZE-1:0] KEY_COLOR  = PIXEL_SIZE'(DEFAULT_KEY_COLOR)
) (
  input  logic [PIXEL_SIZE-1:0] acc_in,
  input  logic [PIXEL_SIZE-1:0] fg,
  input  logic                  skip,
  input  layer_mode_t           mode,
  output logic [PIXEL_SIZE-1:0] acc_out
);

`ifdef PIPELINE_COMPOSITOR_BLEND_EN
  localparam int BLUE_SIZE = PIXEL_SIZE - RED_SIZE - GREEN_SIZE;

  // One extra bit per channel so the sum never wraps before halving.
  logic [RED_SIZE:0]     red_sum;
  logic [GREEN_SIZE:0]   green_sum;
  logic [BLUE_SIZE:0]    blue_sum;
  logic [PIXEL_SIZE-1:0] blend;

  assign red_sum   = {1'b0, acc_in[PIXEL_SIZE-1 -: RED_SIZE]}
                   + {1'b0, fg[PIXEL_SIZE-1 -: RED_SIZE]};
  assign green_sum = {1'b0, acc_in[BLUE_SIZE +: GREEN_SIZE]}
                   + {1'b0, fg[BLUE_SIZE +: GREEN_SIZE]};
  assign blue_sum  = {1'b0, acc_in[0 +: BLUE_SIZE]}
                   + {1'b0, fg[0 +: BLUE_SIZE]};
  assign blend     = {red_sum[RED_SIZE:1], green_sum[GREEN_SIZE:1], blue_sum[BLUE_SIZE:1]};
`endif

  always_comb begin
    // NOTE: default first so every path assigns acc_out and no latch is inferred.
    acc_out = acc_in;
    if (!skip) begin
      case (mode)
        MODE_CHROMA:  if (fg != KEY_COLOR) acc_out = fg;
        MODE_OVERLAY: acc_out = fg;
`ifdef PIPELINE_COMPOSITOR_BLEND_EN
        MODE_BLEND:   acc_out = blend;
`endif
        default:      acc_out = acc_in;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_compositor.sv
// Multi-layer pixel compositor: delays background/position to meet the fetched
// foreground, mixes layers bottom-up and registers the result.
// Optional 50% blend mode: define PIPELINE_COMPOSITOR_BLEND_EN.
module pipeline_compositor
  import pipeline_pkg::*;
#(
  parameter int                    PIXEL_SIZE  = 16,
  parameter int                    RED_SIZE    = 5,
  parameter int                    GREEN_SIZE  = 6,
  parameter logic [PIXEL_SIZE-1:0] KEY_COLOR   = PIXEL_SIZE'(DEFAULT_KEY_COLOR),
  parameter int                    PRECISION   = 11,
  parameter int                    NUM_LAYERS  = 2,
  parameter int                    FETCH_DELAY = 3
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_compositor_if.slave bus
);

  logic [PIXEL_SIZE-1:0] bg_d [FETCH_DELAY];
  logic [PRECISION-1:0]  x_d  [FETCH_DELAY];
  logic [PRECISION-1:0]  y_d  [FETCH_DELAY];
  logic [FETCH_DELAY-1:0] oe_d;

  // NOTE: the delay line is reset on purpose so a reset discards every pixel in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FETCH_DELAY; i++) begin
        bg_d[i] <= '0;
        x_d[i]  <= '0;
        y_d[i]  <= '0;
      end
      oe_d <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift on the same edge.
      bg_d[0] <= bus.bg_pixel_in;
      x_d[0]  <= bus.pixel_x;
      y_d[0]  <= bus.pixel_y;
      oe_d[0] <= bus.output_enable;
      for (int i = 1; i < FETCH_DELAY; i++) begin
        bg_d[i] <= bg_d[i-1];
        x_d[i]  <= x_d[i-1];
        y_d[i]  <= y_d[i-1];
        oe_d[i] <= oe_d[i-1];
      end
    end
  end

  logic [PIXEL_SIZE-1:0]   bg_s;
  logic [PRECISION-1:0]    x_s, y_s;
  logic                    oe_s;
  logic                    frame_origin;
  logic [2*NUM_LAYERS-1:0] shadow_mode;
  logic [2*NUM_LAYERS-1:0] eff_mode;

  assign bg_s = bg_d[FETCH_DELAY-1];
  assign x_s  = x_d[FETCH_DELAY-1];
  assign y_s  = y_d[FETCH_DELAY-1];
  assign oe_s = oe_d[FETCH_DELAY-1];

  // Only an active pixel at (0,0) starts a frame, so flushed (cleared) stages
  // after reset cannot load the shadow modes or fake a frame start.
  assign frame_origin = oe_s && (x_s == '0) && (y_s == '0);
  assign eff_mode     = frame_origin ? bus.ctrl_layer_mode : shadow_mode;

  always_ff @(posedge clk) begin
    if (reset)             shadow_mode <= '0;
    else if (frame_origin) shadow_mode <= bus.ctrl_layer_mode;
  end

  logic [NUM_LAYERS:0][PIXEL_SIZE-1:0] acc;
  assign acc[0] = bg_s;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    pipeline_layer_mix #(
      .PIXEL_SIZE (PIXEL_SIZE),
      .RED_SIZE   (RED_SIZE),
      .GREEN_SIZE (GREEN_SIZE),
      .KEY_COLOR  (KEY_COLOR)
    ) u_mix (
      .acc_in  (acc[g]),
      .fg      (bus.fg_pixel_in[g*PIXEL_SIZE +: PIXEL_SIZE]),
      .skip    (bus.fg_pixel_skip[g]),
      .mode    (layer_mode_t'(eff_mode[MODE_WIDTH*g +: MODE_WIDTH])),
      .acc_out (acc[g+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pixel_out       <= '0;
      bus.pixel_x_out     <= '0;
      bus.pixel_y_out     <= '0;
      bus.pixel_valid_out <= 1'b0;
      bus.frame_start_out <= 1'b0;
    end else begin
      bus.pixel_out       <= oe_s ? acc[NUM_LAYERS] : '0;
      bus.pixel_x_out     <= x_s;
      bus.pixel_y_out     <= y_s;
      bus.pixel_valid_out <= oe_s;
      bus.frame_start_out <= frame_origin;
    end
  end

endmodule
